// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg -- shared definitions for the CPU run controller.
//   state_t              : controller state encoding
//   DEF_HOLD_CYCLES      : default cycles the CPU is held in reset before loading
//   DEF_TIMEOUT          : default maximum RUN cycles waited for cpu_halt
//   DEF_RES_ADDR         : default data-memory byte address of the result
//   LOAD_BYTES           : number of operand bytes written during LOAD
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    LOAD    = 3'd2,
    RUN     = 3'd3,
    READ    = 3'd4,
    RESPOND = 3'd5
  } state_t;

  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_TIMEOUT     = 4096;
  localparam int DEF_RES_ADDR    = 4;
  localparam int LOAD_BYTES      = 4;

endpackage

// File: rtl/run_ctrl.sv
// run_ctrl -- sequences one CPU job per host request.
//   A request (two signed 16-bit operands) is accepted in IDLE. The CPU is
//   held in reset for HOLD_CYCLES, the operands are written little-endian to
//   data-memory bytes 0..3, the CPU is released and run until it halts or
//   TIMEOUT cycles elapse, then the result byte at RES_ADDR is read back and
//   offered to the host until it is consumed.
// Ports:
//   clk, n_rst                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_op0/1   request handshake and operands
//   rsp_valid/rsp_ready             response handshake
//   rsp_result/rsp_timeout          result byte, run ended by timeout
//   cpu_n_rst/cpu_halt              CPU reset (active low) and halt flag
//   dmem_we/addr/wdata/rdata        data-memory port (rdata one cycle late)
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int RES_ADDR    = DEF_RES_ADDR
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_op0,
  input  logic [15:0] req_op1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_timeout,
  output logic        cpu_n_rst,
  input  logic        cpu_halt,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic [7:0]  dmem_rdata
);

  // One counter serves every timed state, so it must reach the larger of
  // the HOLD and RUN limits (LOAD/READ need only 0..3).
  localparam int CNT_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [15:0]        op0_reg, op1_reg;
  logic [7:0]         result_reg, result_next;
  logic               timeout_reg, timeout_next;
  logic               ready_reg;
  logic               handshake;

  // req_ready is registered so that it stays low while n_rst is asserted and
  // rises at the first clock edge after release, independent of req_valid.
  assign req_ready   = ready_reg;
  assign handshake   = req_valid && ready_reg;
  assign rsp_result  = result_reg;
  assign rsp_timeout = timeout_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op0_reg     <= '0;
      op1_reg     <= '0;
      result_reg  <= '0;
      timeout_reg <= 1'b0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      result_reg  <= result_next;
      timeout_reg <= timeout_next;
      ready_reg   <= (state_next == IDLE);
      if (state_reg == IDLE && handshake) begin
        op0_reg <= req_op0;
        op1_reg <= req_op1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    result_next  = result_reg;
    timeout_next = timeout_reg;
    cpu_n_rst    = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = 8'd0;
    dmem_wdata   = 8'd0;
    rsp_valid    = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (handshake) state_next = HOLD;
      end

      HOLD: begin
        if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
          state_next = LOAD;
          cnt_next   = '0;
        end
      end

      // Byte order in memory: op0 low, op0 high, op1 low, op1 high.
      LOAD: begin
        dmem_we   = 1'b1;
        dmem_addr = {6'd0, cnt_reg[1:0]};
        case (cnt_reg[1:0])
          2'd0:    dmem_wdata = op0_reg[7:0];
          2'd1:    dmem_wdata = op0_reg[15:8];
          2'd2:    dmem_wdata = op1_reg[7:0];
          default: dmem_wdata = op1_reg[15:8];
        endcase
        if (cnt_reg[1:0] == 2'(LOAD_BYTES - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end

      // Halt takes priority, so a halt on the final timeout cycle still
      // reports a normal completion.
      RUN: begin
        cpu_n_rst = 1'b1;
        if (cpu_halt) begin
          state_next   = READ;
          timeout_next = 1'b0;
          cnt_next     = '0;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          state_next   = READ;
          timeout_next = 1'b1;
          cnt_next     = '0;
        end
      end

      // Address is presented for two cycles; the memory's registered read
      // data is valid in the second, and captured at its closing edge.
      READ: begin
        cpu_n_rst = 1'b1;
        dmem_addr = 8'(RES_ADDR);
        if (cnt_reg[0]) begin
          result_next = dmem_rdata;
          state_next  = RESPOND;
          cnt_next    = '0;
        end
      end

      RESPOND: begin
        cpu_n_rst = 1'b1;
        rsp_valid = 1'b1;
        cnt_next  = '0;
        if (rsp_ready) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int HOLD = 4;
  localparam int TMO  = 24;
  localparam int RES  = 4;
  localparam int NEVER = 1000000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_op0 = 16'd0;
  logic [15:0] req_op1 = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_result;
  logic        rsp_timeout;
  logic        cpu_n_rst;
  logic        cpu_halt;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  run_ctrl #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO), .RES_ADDR(RES)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .cpu_n_rst(cpu_n_rst), .cpu_halt(cpu_halt),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  // Environment: byte memory with registered read, and a CPU that halts
  // halt_at cycles after its reset is released, storing cpu_byte at RES.
  logic [7:0]  mem [0:255];
  logic [15:0] wr_q [$];
  int          cpu_cnt = 0;
  int          halt_at = NEVER;
  logic [7:0]  cpu_byte = 8'd0;

  assign cpu_halt = cpu_n_rst && (cpu_cnt >= halt_at);

  always @(posedge clk) begin
    if (!cpu_n_rst) cpu_cnt <= 0;
    else            cpu_cnt <= cpu_cnt + 1;
    if (cpu_halt && cpu_cnt == halt_at) mem[RES] <= cpu_byte;
    if (dmem_we) begin
      mem[dmem_addr] <= dmem_wdata;
      wr_q.push_back({dmem_addr, dmem_wdata});
    end
    dmem_rdata <= mem[dmem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full job; the expectations come from the job's rules: the CPU is in
  // reset for HOLD+4 cycles, runs min(halt_at+1, TMO) cycles, reads for 2.
  task automatic txn(input logic [15:0] a, input logic [15:0] b, input int h,
                     input logic [7:0] cb, input int rdy);
    int         lo, hi, exp_run;
    logic       exp_to, ok_busy, ok_stable, done;
    logic [7:0] exp_res;
    exp_to  = (h >= TMO);
    exp_run = exp_to ? TMO : h + 1;
    exp_res = exp_to ? mem[RES] : cb;
    halt_at  = h;
    cpu_byte = cb;
    wr_q.delete();

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_op0 = a; req_op1 = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op0 = ~a; req_op1 = ~b;

    lo = 0; ok_busy = 1'b1; done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_n_rst) begin done = 1'b1; break; end
      lo++;
      if (req_ready) ok_busy = 1'b0;
    end
    chk("cpu_release_seen", 32'(done), 32'd1);
    chk("cpu_rst_low_cycles", 32'(lo), 32'(HOLD + 4));
    chk("write_count", 32'(wr_q.size()), 32'd4);
    if (wr_q.size() == 4) begin
      chk("write0", 32'(wr_q[0]), {16'd0, 8'd0, a[7:0]});
      chk("write1", 32'(wr_q[1]), {16'd0, 8'd1, a[15:8]});
      chk("write2", 32'(wr_q[2]), {16'd0, 8'd2, b[7:0]});
      chk("write3", 32'(wr_q[3]), {16'd0, 8'd3, b[15:8]});
    end

    hi = 0; done = 1'b0;
    for (int i = 0; i < TMO + 50; i++) begin
      if (rsp_valid) begin done = 1'b1; break; end
      hi++;
      if (req_ready || dmem_we) ok_busy = 1'b0;
      @(negedge clk);
    end
    chk("rsp_seen", 32'(done), 32'd1);
    chk("run_read_cycles", 32'(hi), 32'(exp_run + 2));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    chk("rsp_result", 32'(rsp_result), 32'(exp_res));

    ok_stable = 1'b1;
    for (int i = 0; i < rdy; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== exp_res || rsp_timeout !== exp_to || req_ready)
        ok_stable = 1'b0;
    end
    if (rdy > 0) chk("rsp_stable_backpressure", 32'(ok_stable), 32'd1);
    chk("busy_outputs_quiet", 32'(ok_busy), 32'd1);

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cpu_rst_after_rsp", 32'(cpu_n_rst), 32'd0);
    $display("txn op0=%04h op1=%04h halt_at=%0d rdy_delay=%0d result=%02h timeout=%0d reset_cycles=%0d run_read_cycles=%0d",
             a, b, h, rdy, rsp_result, rsp_timeout, lo, hi);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
    chk({tag, "_cpu_n_rst"},   32'(cpu_n_rst),   32'd0);
    chk({tag, "_dmem_we"},     32'(dmem_we),     32'd0);
    chk({tag, "_dmem_addr"},   32'(dmem_addr),   32'd0);
    chk({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_result"},  32'(rsp_result),  32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
  endtask

  initial begin
    logic quiet;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
    mem[RES] = 8'h5A;

    // Power-on reset
    n_rst = 1'b0;
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("ready_before_first_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'd1);

    // Directed jobs
    txn(16'd3, 16'd7, 20, 8'h01, 0);
    txn(16'hFFFF, 16'h8000, 5, 8'hC3, 0);
    txn(16'h1234, 16'hABCD, NEVER, 8'h99, 0);
    txn(16'h0F0F, 16'hF0F0, TMO - 1, 8'h77, 0);
    txn(16'h5555, 16'hAAAA, 2, 8'h10, 10);
    txn(16'h0001, 16'h0002, 0, 8'hE4, 1);

    // Reset pulsed during LOAD after two bytes have been written
    halt_at = 5; cpu_byte = 8'h42; wr_q.delete();
    req_op0 = 16'hBEEF; req_op1 = 16'hCAFE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (HOLD + 3) @(negedge clk);
    chk("abort_writes_before", 32'(wr_q.size()), 32'd2);
    n_rst = 1'b0;
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    quiet = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || cpu_n_rst || dmem_we) quiet = 1'b0;
    end
    chk("abort_no_response", 32'(quiet), 32'd1);
    chk("abort_writes_after", 32'(wr_q.size()), 32'd2);
    txn(16'hBEEF, 16'hCAFE, 7, 8'h3C, 2);

    // Randomized jobs
    for (int k = 0; k < 10; k++) begin
      txn(16'($urandom), 16'($urandom), int'($urandom_range(0, TMO + 3)),
          8'($urandom), int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
